// File: rtl/riscoffee_mem_pkg.sv
// Shared types for the RAM arbiter: access sizes, response owner and response tag.
// No logic, so no latency.
// No backpressure; these are type definitions only.
package riscoffee_mem_pkg;

  // MA_SIZE encodings; 2'd3 is illegal and reported as a misaligned access
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Which requester the response in flight belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MA   = 2'd2
  } owner_e;

  // Everything the response path needs, captured on the grant cycle
  typedef struct packed {
    owner_e     owner;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
    logic       err;
    logic       is_store;
  } rsp_tag_t;

  localparam rsp_tag_t TAG_NONE = '{OWN_NONE, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 3 is never legal
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'd0);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscoffee_mem_lane.sv
// Byte-lane steering for MA: store enables/data replication, load extraction/extension, misalignment.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs in the same cycle.
module riscoffee_mem_lane (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic        st_misaligned,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);
  import riscoffee_mem_pkg::*;

  logic [31:0] ld_shifted;

  assign st_misaligned = is_misaligned(st_size, st_offset);

  // Store side: byte enables by size/offset, data replicated so every lane carries it
  always_comb begin
    st_be   = 4'b0000;
    st_data = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << st_offset;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = 4'b0011 << st_offset;
        st_data = {2{st_wdata[15:0]}};
      end
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Load side: move the addressed lane to bit 0, then sign- or zero-extend
  always_comb begin
    ld_shifted = ld_raw >> {ld_offset, 3'b000};
    ld_data    = ld_raw;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_shifted[7:0]}
                                     : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_shifted[15:0]}
                                     : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/riscoffee_mem_arbiter.sv
// Arbitrates IF and MA onto the single-port RAM and routes read data back to the owner.
// Grant and RAM request are combinational; every response appears exactly 1 cycle after its grant.
// One grant per cycle, MA wins ties; RISCOFFEE_ARB_STARVE_GUARD_EN forces IF through after MAX_DATA_RUN contested MA wins.
module riscoffee_mem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IF_VALID,
  output logic              IF_READY,
  input  logic [31:0]       IF_ADDR,
  output logic              IF_RVALID,
  output logic [31:0]       IF_RDATA,
  input  logic              MA_VALID,
  output logic              MA_READY,
  input  logic              MA_WE,
  input  logic [1:0]        MA_SIZE,
  input  logic              MA_UNSIGNED,
  input  logic [31:0]       MA_ADDR,
  input  logic [31:0]       MA_WDATA,
  output logic              MA_RVALID,
  output logic [31:0]       MA_RDATA,
  output logic              MA_ERR,
  output logic              RAM_EN,
  output logic [3:0]        RAM_WE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [31:0]       RAM_DIN,
  input  logic [31:0]       RAM_DOUT
);
  import riscoffee_mem_pkg::*;

  logic        contested;
  logic        force_if;
  logic        grant_if;
  logic        grant_ma;
  logic        ma_mis;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] ld_data;
  rsp_tag_t    tag_d;
  rsp_tag_t    tag_q;

  // Byte-offset bits and the address bits above the RAM are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IF_ADDR[31:ADDR_W+2], IF_ADDR[1:0], MA_ADDR[31:ADDR_W+2]};

  assign contested = IF_VALID && MA_VALID;

`ifdef RISCOFFEE_ARB_STARVE_GUARD_EN
  localparam logic [3:0] RUN_LIMIT = 4'(MAX_DATA_RUN);
  logic [3:0] run_cnt;

  // Count contested MA wins; any IF grant restarts the run
  always_ff @(posedge CLK) begin
    if (!RST_N)
      run_cnt <= 4'd0;
    else if (grant_if)
      run_cnt <= 4'd0;
    else if (grant_ma && contested)
      run_cnt <= run_cnt + 4'd1;
  end

  assign force_if = contested && (run_cnt == RUN_LIMIT);
`else
  localparam int unused_max_run = MAX_DATA_RUN;
  assign force_if = 1'b0;
`endif

  // Nothing is granted while reset is held, so RAM_EN and READY stay low then
  assign grant_if = RST_N && IF_VALID && (!MA_VALID || force_if);
  assign grant_ma = RST_N && MA_VALID && !grant_if;
  assign IF_READY = grant_if;
  assign MA_READY = grant_ma;

  riscoffee_mem_lane u_lane (
    .st_size       (MA_SIZE),
    .st_offset     (MA_ADDR[1:0]),
    .st_wdata      (MA_WDATA),
    .st_misaligned (ma_mis),
    .st_be         (st_be),
    .st_data       (st_data),
    .ld_size       (tag_q.size),
    .ld_unsigned   (tag_q.is_unsigned),
    .ld_offset     (tag_q.offset),
    .ld_raw        (RAM_DOUT),
    .ld_data       (ld_data)
  );

  // RAM request for the granted side; misaligned MA is granted but never touches the RAM
  always_comb begin
    RAM_EN   = 1'b0;
    RAM_WE   = 4'b0000;
    RAM_ADDR = '0;
    RAM_DIN  = 32'h0;
    if (grant_ma && !ma_mis) begin
      RAM_EN   = 1'b1;
      RAM_ADDR = MA_ADDR[ADDR_W+1:2];
      if (MA_WE) begin
        RAM_WE  = st_be;
        RAM_DIN = st_data;
      end
    end else if (grant_if) begin
      RAM_EN   = 1'b1;
      RAM_ADDR = IF_ADDR[ADDR_W+1:2];
    end
  end

  // Describe this cycle's grant so next cycle's response can be decoded
  always_comb begin
    tag_d = TAG_NONE;
    if (grant_if) begin
      tag_d.owner = OWN_IF;
    end else if (grant_ma) begin
      tag_d.owner       = OWN_MA;
      tag_d.size        = MA_SIZE;
      tag_d.is_unsigned = MA_UNSIGNED;
      tag_d.offset      = MA_ADDR[1:0];
      tag_d.err         = ma_mis;
      tag_d.is_store    = MA_WE;
    end
  end

  // Response tag register; reset drops whatever was in flight
  always_ff @(posedge CLK) begin
    if (!RST_N)
      tag_q <= TAG_NONE;
    else
      tag_q <= tag_d;
  end

  // Responses are also masked by RST_N so a reset asserted mid-access shows nothing
  assign IF_RVALID = RST_N && (tag_q.owner == OWN_IF);
  assign IF_RDATA  = IF_RVALID ? RAM_DOUT : 32'h0;
  assign MA_RVALID = RST_N && (tag_q.owner == OWN_MA);
  assign MA_ERR    = MA_RVALID && tag_q.err;
  assign MA_RDATA  = (MA_RVALID && !tag_q.err && !tag_q.is_store) ? ld_data : 32'h0;

endmodule

// File: tb/tb_riscoffee_mem_arbiter.sv
module tb_riscoffee_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ma_valid, ma_ready, ma_we, ma_unsigned, ma_rvalid, ma_err;
  logic [1:0]  ma_size;
  logic [31:0] ma_addr, ma_wdata, ma_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  riscoffee_mem_arbiter #(.ADDR_W(14), .MAX_DATA_RUN(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IF_VALID(if_valid), .IF_READY(if_ready), .IF_ADDR(if_addr),
    .IF_RVALID(if_rvalid), .IF_RDATA(if_rdata),
    .MA_VALID(ma_valid), .MA_READY(ma_ready), .MA_WE(ma_we), .MA_SIZE(ma_size),
    .MA_UNSIGNED(ma_unsigned), .MA_ADDR(ma_addr), .MA_WDATA(ma_wdata),
    .MA_RVALID(ma_rvalid), .MA_RDATA(ma_rdata), .MA_ERR(ma_err),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din),
    .RAM_DOUT(ram_dout)
  );

  // Single-port synchronous RAM model, read-before-write
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  typedef struct {
    logic        iv;  logic [31:0] ia;
    logic        mv;  logic mwe; logic [1:0] msz; logic mu; logic [31:0] ma; logic [31:0] mwd;
    logic        e_ir; logic e_mr; logic e_en; logic [3:0] e_we; logic [13:0] e_addr; logic [31:0] e_din;
    logic        e_irv; logic [31:0] e_ird;
    logic        e_mrv; logic [31:0] e_mrd; logic e_merr;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_valid = 1'b0; if_addr = 32'h0;
    ma_valid = 1'b0; ma_we = 1'b0; ma_size = 2'd0; ma_unsigned = 1'b0;
    ma_addr = 32'h0; ma_wdata = 32'h0;
  endtask

  task automatic ma_req(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    ma_valid = 1'b1; ma_we = we; ma_size = sz; ma_unsigned = u; ma_addr = a; ma_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {19'b0, if_ready, ma_ready, if_rvalid, ma_rvalid, ma_err, ram_en, ram_we,
            (|if_rdata), (|ma_rdata)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[4] = 32'h00500093;

    //         iv ia          mv we sz    u  ma          mwd            ir mr en we       addr    din             irv ird            mrv mrd            err
    vecs[0]  = '{1, 32'h10,   0, 0, 2'd0, 0, 32'h0,  32'h0,          1, 0, 1, 4'h0,    14'd4, 32'h0,          0, 32'h0,          0, 32'h0,          0};
    vecs[1]  = '{0, 32'h0,    1, 1, 2'd0, 0, 32'h13, 32'hAB,         0, 1, 1, 4'b1000, 14'd4, 32'hABABABAB,   1, 32'h00500093,   0, 32'h0,          0};
    vecs[2]  = '{0, 32'h0,    1, 0, 2'd0, 0, 32'h13, 32'h0,          0, 1, 1, 4'h0,    14'd4, 32'h0,          0, 32'h0,          1, 32'h0,          0};
    vecs[3]  = '{0, 32'h0,    1, 0, 2'd0, 1, 32'h13, 32'h0,          0, 1, 1, 4'h0,    14'd4, 32'h0,          0, 32'h0,          1, 32'hFFFFFFAB,   0};
    vecs[4]  = '{0, 32'h0,    1, 0, 2'd2, 0, 32'h22, 32'h0,          0, 1, 0, 4'h0,    14'd0, 32'h0,          0, 32'h0,          1, 32'h000000AB,   0};
    vecs[5]  = '{0, 32'h0,    1, 1, 2'd1, 0, 32'h22, 32'h12345678,   0, 1, 1, 4'b1100, 14'd8, 32'h56785678,   0, 32'h0,          1, 32'h0,          1};
    vecs[6]  = '{0, 32'h0,    1, 0, 2'd1, 0, 32'h22, 32'h0,          0, 1, 1, 4'h0,    14'd8, 32'h0,          0, 32'h0,          1, 32'h0,          0};
    vecs[7]  = '{0, 32'h0,    1, 0, 2'd3, 0, 32'h40, 32'h0,          0, 1, 0, 4'h0,    14'd0, 32'h0,          0, 32'h0,          1, 32'h00005678,   0};
    vecs[8]  = '{0, 32'h0,    1, 1, 2'd1, 0, 32'h21, 32'hFFFF,       0, 1, 0, 4'h0,    14'd0, 32'h0,          0, 32'h0,          1, 32'h0,          1};
    vecs[9]  = '{0, 32'h0,    1, 1, 2'd1, 0, 32'h20, 32'h8001,       0, 1, 1, 4'b0011, 14'd8, 32'h80018001,   0, 32'h0,          1, 32'h0,          1};
    vecs[10] = '{0, 32'h0,    1, 0, 2'd1, 0, 32'h20, 32'h0,          0, 1, 1, 4'h0,    14'd8, 32'h0,          0, 32'h0,          1, 32'h0,          0};
    vecs[11] = '{0, 32'h0,    0, 0, 2'd0, 0, 32'h0,  32'h0,          0, 0, 0, 4'h0,    14'd0, 32'h0,          0, 32'h0,          1, 32'hFFFF8001,   0};
    vecs[12] = '{0, 32'h0,    1, 1, 2'd2, 0, 32'h24, 32'hDEADBEEF,   0, 1, 1, 4'hF,    14'd9, 32'hDEADBEEF,   0, 32'h0,          0, 32'h0,          0};
    vecs[13] = '{0, 32'h0,    1, 0, 2'd0, 0, 32'h25, 32'h0,          0, 1, 1, 4'h0,    14'd9, 32'h0,          0, 32'h0,          1, 32'h0,          0};
    vecs[14] = '{1, 32'h24,   1, 0, 2'd2, 0, 32'h24, 32'h0,          0, 1, 1, 4'h0,    14'd9, 32'h0,          0, 32'h0,          1, 32'hFFFFFFBE,   0};
    vecs[15] = '{1, 32'h24,   0, 0, 2'd0, 0, 32'h0,  32'h0,          1, 0, 1, 4'h0,    14'd9, 32'h0,          0, 32'h0,          1, 32'hDEADBEEF,   0};
    vecs[16] = '{0, 32'h0,    0, 0, 2'd0, 0, 32'h0,  32'h0,          0, 0, 0, 4'h0,    14'd0, 32'h0,          1, 32'hDEADBEEF,   0, 32'h0,          0};
    vecs[17] = '{0, 32'h0,    0, 0, 2'd0, 0, 32'h0,  32'h0,          0, 0, 0, 4'h0,    14'd0, 32'h0,          0, 32'h0,          0, 32'h0,          0};

    // Reset: READY and RAM_EN held low even with both requesters valid
    drive_idle();
    rst_n = 1'b0;
    if_valid = 1'b1; if_addr = 32'h10;
    ma_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("rst_ready_en", {29'b0, if_ready, ma_ready, ram_en}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst_outputs", all_outs(), 32'h0);
    next_cycle();
    drive_idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", all_outs(), 32'h0);
    next_cycle();

    // Directed vector table, one row per cycle
    for (int i = 0; i < 18; i++) begin
      if_valid = vecs[i].iv; if_addr = vecs[i].ia;
      ma_valid = vecs[i].mv; ma_we = vecs[i].mwe; ma_size = vecs[i].msz;
      ma_unsigned = vecs[i].mu; ma_addr = vecs[i].ma; ma_wdata = vecs[i].mwd;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {30'b0, if_ready, ma_ready}, {30'b0, vecs[i].e_ir, vecs[i].e_mr});
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      if (vecs[i].e_en) chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we != 4'h0) chk($sformatf("v%0d_ram_din", i), ram_din, vecs[i].e_din);
      chk($sformatf("v%0d_if_rsp", i), {31'b0, if_rvalid}, 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_ird);
      chk($sformatf("v%0d_ma_rsp", i), {30'b0, ma_rvalid, ma_err}, {30'b0, vecs[i].e_mrv, vecs[i].e_merr});
      chk($sformatf("v%0d_ma_rdata", i), ma_rdata, vecs[i].e_mrd);
      next_cycle();
    end

    // Both requesters valid for 10 cycles
    do_reset();
    begin
      logic prev_if;
      prev_if = 1'b0;
      for (int c = 0; c < 10; c++) begin
        logic exp_if;
`ifdef RISCOFFEE_ARB_STARVE_GUARD_EN
        exp_if = (c == 4) || (c == 9);
`else
        exp_if = 1'b0;
`endif
        if_valid = 1'b1; if_addr = 32'h10;
        ma_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        chk($sformatf("contest%0d_grant", c), {30'b0, if_ready, ma_ready}, {30'b0, exp_if, !exp_if});
        if (c > 0)
          chk($sformatf("contest%0d_rsp", c), {30'b0, if_rvalid, ma_rvalid}, {30'b0, prev_if, !prev_if});
        prev_if = exp_if;
        next_cycle();
      end
      drive_idle();
      next_cycle();
    end

    // Reset asserted the cycle after a granted MA load drops the response
    do_reset();
    ma_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk("midrst_grant", {31'b0, ma_ready}, 32'h1);
    next_cycle();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_no_rsp", {31'b0, ma_rvalid}, 32'h0);
    chk("midrst_outputs", all_outs(), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_idle", all_outs(), 32'h0);
    next_cycle();
    if_valid = 1'b1; if_addr = 32'h10;
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("midrst_first_fetch", if_rdata, 32'hAB500093);
    next_cycle();

    // Alternating IF/MA grants, data must return to the right owner
    for (int i = 0; i <= 8; i++) begin
      drive_idle();
      if (i < 8) begin
        if (i % 2 == 0) begin
          if_valid = 1'b1; if_addr = 32'((64 + i) * 4);
        end else begin
          ma_req(1'b0, 2'd2, 1'b0, 32'((64 + i) * 4), 32'h0);
        end
      end
      @(negedge clk);
      if (i > 0) begin
        logic [31:0] exp_word;
        exp_word = 32'hC0DE0000 | 32'(64 + i - 1);
        if ((i - 1) % 2 == 0) begin
          chk($sformatf("alt%0d_owner", i - 1), {30'b0, if_rvalid, ma_rvalid}, 32'h2);
          chk($sformatf("alt%0d_data", i - 1), if_rdata, exp_word);
          chk($sformatf("alt%0d_other", i - 1), ma_rdata, 32'h0);
        end else begin
          chk($sformatf("alt%0d_owner", i - 1), {30'b0, if_rvalid, ma_rvalid}, 32'h1);
          chk($sformatf("alt%0d_data", i - 1), ma_rdata, exp_word);
          chk($sformatf("alt%0d_other", i - 1), if_rdata, 32'h0);
        end
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
